// File: rtl/truth_table_checker.sv
// truth_table_checker
// Exhaustive sequential tester for an N-input, single-output combinational gate.
// Drives each input vector 0 .. 2^N-1 onto vec and holds it for SETTLE cycles.
// It then samples dut_s against the latched minterm mask and tallies mismatches.
// Optional feature: define TRUTH_TABLE_CHECKER_MISMATCH_MAP_EN to add the
// per-vector mismatch_map output.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for start; results of the last sweep are held
//   APPLY  | vec driven, settle counter running down to zero
//   SAMPLE | compare dut_s with expected[vec], advance or finish
//   DONE   | one-cycle done pulse, pass resolved from the final count
module truth_table_checker #(
  parameter int N      = 2,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [2**N-1:0]   expected,
  input  logic              dut_s,
  output logic [N-1:0]      vec,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N:0]        err_count,
  output logic [N-1:0]      first_fail,
  output logic              fail_seen
`ifdef TRUTH_TABLE_CHECKER_MISMATCH_MAP_EN
  ,
  output logic [2**N-1:0]   mismatch_map
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state;
  logic [2**N-1:0]   exp_q;
  logic [3:0]        settle_cnt;
  logic              last_vec;
  logic              mismatch;

  // The mask is latched at start, so the comparison never sees a live change of expected.
  assign last_vec = (vec == {N{1'b1}});
  assign mismatch = (dut_s != exp_q[vec]);

  // Sweep sequencer with all outputs registered; abort outranks sampling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      exp_q      <= '0;
      settle_cnt <= '0;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
      fail_seen  <= 1'b0;
`ifdef TRUTH_TABLE_CHECKER_MISMATCH_MAP_EN
      mismatch_map <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            exp_q      <= expected;
            err_count  <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
            pass       <= 1'b0;
            vec        <= '0;
            settle_cnt <= 4'(SETTLE - 1);
            busy       <= 1'b1;
`ifdef TRUTH_TABLE_CHECKER_MISMATCH_MAP_EN
            mismatch_map <= '0;
`endif
            state      <= S_APPLY;
          end
        end

        S_APPLY: begin
          if (abort) begin
            busy  <= 1'b0;
            pass  <= 1'b0;
            state <= S_IDLE;
          end else if (settle_cnt == 4'd0) begin
            state <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end

        S_SAMPLE: begin
          if (abort) begin
            busy  <= 1'b0;
            pass  <= 1'b0;
            state <= S_IDLE;
          end else begin
            if (mismatch) begin
              err_count <= err_count + (N+1)'(1);
              if (!fail_seen) begin
                first_fail <= vec;
                fail_seen  <= 1'b1;
              end
`ifdef TRUTH_TABLE_CHECKER_MISMATCH_MAP_EN
              mismatch_map[vec] <= 1'b1;
`endif
            end
            if (last_vec) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              vec        <= vec + N'(1);
              settle_cnt <= 4'(SETTLE - 1);
              state      <= S_APPLY;
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          pass  <= (err_count == '0);
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: one N=2/SETTLE=1 instance and one
// N=3/SETTLE=3 instance, each driven by a small behavioural gate model.
module tb_truth_table_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       start_a, abort_a, dut_s_a, mode_a;
  logic [3:0] expected_a;
  logic [1:0] vec_a, first_fail_a;
  logic [2:0] err_count_a;
  logic       busy_a, done_a, pass_a, fail_seen_a;

  logic       start_b, abort_b, dut_s_b;
  logic [7:0] expected_b;
  logic [2:0] vec_b, first_fail_b;
  logic [3:0] err_count_b;
  logic       busy_b, done_b, pass_b, fail_seen_b;

`ifdef TRUTH_TABLE_CHECKER_MISMATCH_MAP_EN
  logic [3:0] mismatch_map_a;
  logic [7:0] mismatch_map_b;
`endif

  int total = 0;
  int bad   = 0;

  // mode_a=0: ~a & b (the function behind mask 4'b0010); mode_a=1: a & b
  assign dut_s_a = mode_a ? (vec_a == 2'b11) : (vec_a == 2'b01);
  assign dut_s_b = ^vec_b;

  truth_table_checker #(.N(2), .SETTLE(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .expected(expected_a), .dut_s(dut_s_a), .vec(vec_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .err_count(err_count_a),
    .first_fail(first_fail_a), .fail_seen(fail_seen_a)
`ifdef TRUTH_TABLE_CHECKER_MISMATCH_MAP_EN
    , .mismatch_map(mismatch_map_a)
`endif
  );

  truth_table_checker #(.N(3), .SETTLE(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .expected(expected_b), .dut_s(dut_s_b), .vec(vec_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .err_count(err_count_b),
    .first_fail(first_fail_b), .fail_seen(fail_seen_b)
`ifdef TRUTH_TABLE_CHECKER_MISMATCH_MAP_EN
    , .mismatch_map(mismatch_map_b)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic start_sweep_a(input logic [3:0] mask, input logic m);
    expected_a = mask;
    mode_a     = m;
    start_a    = 1'b1;
    tick();
    start_a    = 1'b0;
  endtask

  task automatic wait_done_a(output int cyc);
    cyc = 0;
    while (done_a !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_done_b(output int cyc);
    cyc = 0;
    while (done_b !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int dcount;

    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; mode_a = 1'b0; expected_a = '0;
    start_b = 1'b0; abort_b = 1'b0; expected_b = '0;
    repeat (2) tick();

    check("rst_vec",   32'(vec_a), 32'd0);
    check("rst_busy",  32'(busy_a), 32'd0);
    check("rst_done",  32'(done_a), 32'd0);
    check("rst_pass",  32'(pass_a), 32'd0);
    check("rst_err",   32'(err_count_a), 32'd0);
    check("rst_ff",    32'(first_fail_a), 32'd0);
    check("rst_fs",    32'(fail_seen_a), 32'd0);
    rst_n = 1'b1;
    tick();

    // reset in the middle of a failing sweep
    start_sweep_a(4'b0010, 1'b1);
    repeat (4) tick();
    check("mid_vec_pre", 32'(vec_a), 32'd2);
    check("mid_err_pre", 32'(err_count_a), 32'd1);
    rst_n = 1'b0;
    #2;
    check("arst_vec",  32'(vec_a), 32'd0);
    check("arst_busy", 32'(busy_a), 32'd0);
    check("arst_err",  32'(err_count_a), 32'd0);
    check("arst_fs",   32'(fail_seen_a), 32'd0);
    check("arst_ff",   32'(first_fail_a), 32'd0);
    check("arst_pass", 32'(pass_a), 32'd0);
`ifdef TRUTH_TABLE_CHECKER_MISMATCH_MAP_EN
    check("arst_map",  32'(mismatch_map_a), 32'd0);
`endif
    dcount = 0;
    repeat (3) begin
      tick();
      if (done_a) dcount++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      tick();
      if (done_a) dcount++;
    end
    check("arst_no_done", 32'(dcount), 32'd0);
    check("arst_idle", 32'(busy_a), 32'd0);

    // correct DUT
    start_sweep_a(4'b0010, 1'b0);
    check("ok_busy0", 32'(busy_a), 32'd1);
    wait_done_a(cyc);
    check("ok_latency", 32'(cyc), 32'd8);
    check("ok_busy_done", 32'(busy_a), 32'd1);
    tick();
    check("ok_done_1cyc", 32'(done_a), 32'd0);
    check("ok_pass", 32'(pass_a), 32'd1);
    check("ok_err",  32'(err_count_a), 32'd0);
    check("ok_fs",   32'(fail_seen_a), 32'd0);
    check("ok_busy", 32'(busy_a), 32'd0);
    check("ok_vec",  32'(vec_a), 32'd3);

    // wrong DUT (a & b) against the same mask
    start_sweep_a(4'b0010, 1'b1);
    check("bad_pass_clr", 32'(pass_a), 32'd0);
    wait_done_a(cyc);
    check("bad_latency", 32'(cyc), 32'd8);
    tick();
    check("bad_err",  32'(err_count_a), 32'd2);
    check("bad_ff",   32'(first_fail_a), 32'd1);
    check("bad_fs",   32'(fail_seen_a), 32'd1);
    check("bad_pass", 32'(pass_a), 32'd0);
`ifdef TRUTH_TABLE_CHECKER_MISMATCH_MAP_EN
    check("bad_map",  32'(mismatch_map_a), 32'hA);
`endif

    // abort at vec=2, with a stray start while busy
    start_sweep_a(4'b0010, 1'b1);
    tick();
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    check("abt_vec",  32'(vec_a), 32'd2);
    check("abt_err_pre", 32'(err_count_a), 32'd1);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check("abt_busy", 32'(busy_a), 32'd0);
    check("abt_pass", 32'(pass_a), 32'd0);
    check("abt_err",  32'(err_count_a), 32'd1);
    check("abt_ff",   32'(first_fail_a), 32'd1);
    check("abt_fs",   32'(fail_seen_a), 32'd1);
    dcount = 0;
    repeat (20) begin
      tick();
      if (done_a) dcount++;
    end
    check("abt_no_done", 32'(dcount), 32'd0);
    check("abt_pass_end", 32'(pass_a), 32'd0);

    // back-to-back sweeps, N=3 SETTLE=3, start held; start+abort together starts
    expected_b = 8'b1001_0110;
    start_b = 1'b1;
    abort_b = 1'b1;
    tick();
    abort_b = 1'b0;
    check("b2b_start_wins", 32'(busy_b), 32'd1);
    wait_done_b(cyc);
    check("b2b_lat1", 32'(cyc), 32'd32);
    tick();
    check("b2b_pass1", 32'(pass_b), 32'd1);
    check("b2b_err1",  32'(err_count_b), 32'd0);
    check("b2b_idle",  32'(busy_b), 32'd0);
    tick();
    check("b2b_restart", 32'(busy_b), 32'd1);
    check("b2b_pass_clr", 32'(pass_b), 32'd0);
    check("b2b_vec0", 32'(vec_b), 32'd0);
    wait_done_b(cyc);
    check("b2b_lat2", 32'(cyc), 32'd32);
    start_b = 1'b0;
    tick();
    check("b2b_pass2", 32'(pass_b), 32'd1);
    check("b2b_err2",  32'(err_count_b), 32'd0);
    check("b2b_fs2",   32'(fail_seen_b), 32'd0);
    check("b2b_vec_last", 32'(vec_b), 32'd7);
`ifdef TRUTH_TABLE_CHECKER_MISMATCH_MAP_EN
    check("b2b_map",   32'(mismatch_map_b), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Sequential exhaustive tester for combinational gate modules with N inputs and one output, generalising our fixed four-row gate benches.
- Sweeps every input vector 0 … 2^N−1 into the device under test (DUT).
- Waits a programmable settle time per vector, then compares the DUT output against a minterm mask.
- Reports pass/fail, mismatch count and the first failing vector.
- Sits beside a gate module inside a test wrapper, driving the DUT inputs directly.

## Interface

Parameters:
- N, default 2: number of DUT inputs; legal range 1–8.
- SETTLE, default 1: cycles each vector is held before sampling; legal range 1–15.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- abort  input  1  synchronous abandon of a running sweep.
- expected  input  2^N  minterm mask; bit m is the required DUT output for vector m. Latched at start.
- dut_s  input  1  output of the DUT.
- vec  output  N  vector driven to the DUT inputs; bit N−1 is the MSB (first DUT input).
- busy  output  1  high while a sweep is running.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  high when the last completed sweep had zero mismatches.
- err_count  output  N+1  mismatches in the current or last sweep.
- first_fail  output  N  lowest failing vector; valid when fail_seen=1.
- fail_seen  output  1  at least one mismatch has occurred.

## Operation

Reset (rst_n=0, asynchronous):
- State goes to IDLE.
- vec=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, fail_seen=0.
- The mismatch map, when compiled in, clears.

IDLE:
- start=1 latches expected and clears err_count, first_fail, fail_seen and pass.
- vec is set to 0, the settle counter is loaded with SETTLE−1, and the block moves to APPLY.

APPLY:
- vec is held constant.
- The settle counter decrements each cycle. When it reaches 0, the block moves to SAMPLE.

SAMPLE (one cycle):
- Compare dut_s with the latched expected[vec].
- On mismatch:
  - err_count increments.
  - If fail_seen=0, first_fail is set to vec and fail_seen goes to 1.
- If vec = 2^N−1, move to DONE. Otherwise vec increments, the settle counter reloads and the block returns to APPLY.

DONE (one cycle):
- done=1.
- pass is set to (err_count==0), using the final count including the last sample.
- Return to IDLE.
- vec stays at 2^N−1 until the next start.

Control rules:
- abort=1 in APPLY or SAMPLE takes priority over sampling. The block returns to IDLE with pass=0 and no done pulse; err_count and fail fields keep their partial values.
- abort is ignored in IDLE and DONE.
- start is ignored while busy. start and abort asserted together in IDLE means start wins.
- busy=1 in APPLY, SAMPLE and DONE.
- err_count never overflows: its maximum value is 2^N, which fits in N+1 bits.

## Timing

- After the start edge, vec=0 is visible on the DUT for SETTLE cycles before it is sampled.
- Each vector occupies SETTLE+1 cycles.
- done is asserted exactly 2^N·(SETTLE+1) cycles after the start edge, for one cycle. With N=2 and SETTLE=1, that is 8 cycles.
- err_count and fail_seen update on the SAMPLE edge. pass updates on the DONE edge.
- A new start is accepted in the cycle after DONE (back-to-back sweeps).
- Deasserting rst_n mid-sweep clears everything immediately. No done pulse is produced.

## Configuration

- Macro: TRUTH_TABLE_CHECKER_MISMATCH_MAP_EN.
- Defined:
  - Adds output port mismatch_map, width 2^N.
  - Bit m is set on the SAMPLE edge when vector m mismatched.
  - The map clears on start and on reset.
- Undefined: the port and its register are absent. All other behaviour is identical.

## Test plan

- Reset mid-sweep: assert rst_n=0 during APPLY → all outputs 0 asynchronously, state IDLE, no done pulse.
- Correct DUT: N=2, SETTLE=1, expected=4'b0010, DUT is the combinational reference model of the function behind that mask → done 8 cycles after start, pass=1, err_count=0, fail_seen=0.
- Wrong DUT: DUT replaced by a&b, same mask → err_count=2, first_fail=2'd1, fail_seen=1, pass=0; with the macro defined, mismatch_map=4'b1010.
- Abort: abort=1 while vec=2 → busy drops the next cycle, done never pulses, pass=0; start ignored while busy.
- Back-to-back and parameter scaling: two sweeps with start held high, using N=3, SETTLE=3, and an XOR-of-three DUT against mask 8'b10010110 → each done 32 cycles apart, both pass=1, err_count resets between sweeps.
